// File: rtl/sata_oob_controller_if.sv
// sata_oob_controller_if: phy-side OOB/dword signals and link-layer status of the SATA OOB controller.
interface sata_oob_controller_if;
   logic        i_en;
   logic        i_pll_detect;
   logic        i_reset_done;
   logic        i_dcm_locked;
   logic        i_rx_cominit;
   logic        i_rx_comwake;
   logic        i_rx_elec_idle;
   logic [31:0] i_rx_data;
   logic        i_rx_char_is_k;
   logic        o_tx_comm_start;
   logic        o_tx_comm_type;
   logic        o_tx_elec_idle;
   logic [31:0] o_tx_data;
   logic        o_tx_char_is_k;
   logic        o_link_up;
   logic [3:0]  o_state;
   logic [7:0]  o_retry_count;
   logic        o_link_fail;
   modport master (
      input  i_en, i_pll_detect, i_reset_done, i_dcm_locked, i_rx_cominit, i_rx_comwake,
             i_rx_elec_idle, i_rx_data, i_rx_char_is_k,
      output o_tx_comm_start, o_tx_comm_type, o_tx_elec_idle, o_tx_data, o_tx_char_is_k,
             o_link_up, o_state, o_retry_count, o_link_fail
   );
   modport slave (
      output i_en, i_pll_detect, i_reset_done, i_dcm_locked, i_rx_cominit, i_rx_comwake,
             i_rx_elec_idle, i_rx_data, i_rx_char_is_k,
      input  o_tx_comm_start, o_tx_comm_type, o_tx_elec_idle, o_tx_data, o_tx_char_is_k,
             o_link_up, o_state, o_retry_count, o_link_fail
   );
endinterface

// File: rtl/sata_oob_controller.sv
// sata_oob_controller: host-side SATA OOB sequencer (COMRESET/COMWAKE/ALIGN) reporting link-up.
// Define SATA_OOB_RETRY_LIMIT_EN to give up in FAIL after MAX_RETRY unanswered COMRESETs.
module sata_oob_controller #(
   parameter int BURST_CYCLES  = 512,
   parameter int RESP_TIMEOUT  = 66000,
   parameter int ALIGN_TIMEOUT = 66000,
   parameter int NONALIGN_CNT  = 3
`ifdef SATA_OOB_RETRY_LIMIT_EN
   , parameter int MAX_RETRY   = 8
`endif
) (
   input logic clk,
   input logic rst_n,
   sata_oob_controller_if.master bus
);
   localparam logic [3:0] IDLE = 4'd0, COMRESET = 4'd1, WAIT_COMINIT = 4'd2, COMWAKE = 4'd3,
                          WAIT_COMWAKE = 4'd4, WAIT_NOCOMWAKE = 4'd5, WAIT_ALIGN = 4'd6,
                          SEND_ALIGN = 4'd7, READY = 4'd8, FAIL = 4'd9;
   localparam logic [31:0] D10_2 = 32'h4A4A4A4A, ALIGN = 32'h7B4A4ABC;
   logic [3:0] state, seq, nxt;
   logic [19:0] cnt;
   logic en_q, abort, rx_align, late, ent, burst_done, resp_to, align_to;
   always_comb begin
      abort = !bus.i_en || !bus.i_pll_detect;
      rx_align = bus.i_rx_char_is_k && bus.i_rx_data == ALIGN;
      late = state >= COMWAKE && state <= READY;
      burst_done = cnt == 20'(BURST_CYCLES - 1);
      resp_to = cnt == 20'(RESP_TIMEOUT - 1);
      align_to = cnt == 20'(ALIGN_TIMEOUT - 1);
      seq = state;
      case (state)
         IDLE:           seq = (bus.i_en && bus.i_pll_detect && bus.i_reset_done && bus.i_dcm_locked) ? COMRESET : IDLE;
         COMRESET:       seq = burst_done ? WAIT_COMINIT : COMRESET;
         WAIT_COMINIT:   seq = bus.i_rx_cominit ? COMWAKE : resp_to ? COMRESET : WAIT_COMINIT;
         COMWAKE:        seq = burst_done ? WAIT_COMWAKE : COMWAKE;
         WAIT_COMWAKE:   seq = bus.i_rx_comwake ? WAIT_NOCOMWAKE : resp_to ? COMRESET : WAIT_COMWAKE;
         WAIT_NOCOMWAKE: seq = bus.i_rx_elec_idle ? WAIT_NOCOMWAKE : WAIT_ALIGN;
         WAIT_ALIGN:     seq = rx_align ? SEND_ALIGN : align_to ? COMRESET : WAIT_ALIGN;
         SEND_ALIGN:     seq = (!rx_align && cnt == 20'(NONALIGN_CNT - 1)) ? READY : SEND_ALIGN;
         READY:          seq = READY;
         FAIL:           seq = (bus.i_en && !en_q) ? IDLE : FAIL;
         default:        seq = IDLE;
      endcase
      // an unsolicited device COMINIT restarts the wake handshake from any later state
      if (late && bus.i_rx_cominit) seq = COMWAKE;
      if (abort && state != IDLE && state != FAIL) seq = IDLE;
      nxt = seq;
`ifdef SATA_OOB_RETRY_LIMIT_EN
      if (seq == COMRESET && state != COMRESET && bus.o_retry_count == 8'(MAX_RETRY)) nxt = FAIL;
`endif
      ent = nxt != state;
   end
   assign bus.o_state = state;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         en_q <= 1'b0;
         bus.o_tx_comm_start <= 1'b0;
         bus.o_tx_comm_type <= 1'b0;
         bus.o_tx_elec_idle <= 1'b1;
         bus.o_tx_data <= '0;
         bus.o_tx_char_is_k <= 1'b0;
         bus.o_link_up <= 1'b0;
         bus.o_retry_count <= '0;
`ifdef SATA_OOB_RETRY_LIMIT_EN
         bus.o_link_fail <= 1'b0;
`endif
      end else begin
         state <= nxt;
         en_q <= bus.i_en;
         // in SEND_ALIGN the counter tracks consecutive non-ALIGN dwords instead of time
         cnt <= (ent || (state == SEND_ALIGN && rx_align)) ? '0 : cnt + 20'd1;
         bus.o_tx_comm_start <= ent && (nxt == COMRESET || nxt == COMWAKE);
         bus.o_tx_comm_type <= nxt == COMWAKE;
         bus.o_tx_elec_idle <= !(nxt == WAIT_ALIGN || nxt == SEND_ALIGN || nxt == READY);
         bus.o_tx_data <= nxt == WAIT_ALIGN ? D10_2 : (nxt == SEND_ALIGN || nxt == READY) ? ALIGN : '0;
         bus.o_tx_char_is_k <= nxt == SEND_ALIGN || nxt == READY;
         bus.o_link_up <= nxt == READY;
         bus.o_retry_count <= (nxt == IDLE || nxt == READY) ? '0 :
                              (ent && nxt == COMRESET && bus.o_retry_count != 8'hFF) ? bus.o_retry_count + 8'd1 :
                              bus.o_retry_count;
`ifdef SATA_OOB_RETRY_LIMIT_EN
         bus.o_link_fail <= nxt == FAIL;
`endif
      end
   end
`ifndef SATA_OOB_RETRY_LIMIT_EN
   assign bus.o_link_fail = 1'b0;
`endif
endmodule
